pending_or_collector: RTL

//  Parametrised, registered successor to the fixed 15-input bubble OR gate.
//  Per-input inversion, level/edge mode, enable mask and sticky pending bits.

---
 rtl/pending_or_collector_pkg.sv | 31 +++
 rtl/lowest_set_index.sv | 35 +++
 rtl/pending_or_collector.sv | 119 +++++++++++
 3 files changed

// File: rtl/pending_or_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pending_or_collector_pkg
// Purpose  : Shared limits, default masks and a width helper for the
//            pending/OR request collector and its priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
package pending_or_collector_pkg;

    // Largest supported number of request inputs; masks are sized to this.
    localparam int c_MAX_INPUTS = 32;

    // Default masks: no inversion, every input level-sensitive.
    localparam logic [c_MAX_INPUTS-1:0] c_DEFAULT_BUBBLES_MASK = '0;
    localparam logic [c_MAX_INPUTS-1:0] c_DEFAULT_EDGE_MASK    = '0;

    // Ceiling log2, clamped to at least one bit so a 2-input build still
    // gets a usable index port.
    function automatic int idx_width(input int value);
        int w;
        w = 1;
        for (int b = 1; b < 31; b++) begin
            if ((1 << b) < value) begin
                w = b + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lowest_set_index.sv
`default_nettype none
// ============================================================================
// Module   : lowest_set_index
// Purpose  : Combinational priority encoder. Reports whether any bit of the
//            input vector is set and the index of the lowest set bit
//            (0 when none is set).
// Ports    : i_vec [WIDTH]  vector to scan
//            any            1 when any bit of i_vec is set
//            idx  [IDX_W]   lowest set bit position, 0 if none
// Revision : 1.0 - initial release
// ============================================================================
module lowest_set_index
    import pending_or_collector_pkg::*;
#(
    parameter int WIDTH = 15,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // Scanning from the top down lets the lowest set bit write last.
    always_comb begin
        any = |i_vec;
        idx = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (i_vec[k]) begin
                idx = k[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pending_or_collector.sv
`default_nettype none
// ============================================================================
// Module   : pending_or_collector
// Purpose  : Registered interrupt/event aggregator. Each request input can be
//            inverted, optionally synchronised, and treated either as a level
//            (follows the input) or a rising edge (sticky until cleared).
//            Produces the registered OR of enabled pending bits and the
//            lowest enabled pending index.
// Ports    : Clock        rising-edge clock
//            Reset        synchronous active-high reset (overrides Tick)
//            Tick         clock enable, 0 holds every register
//            Inputs      [N] raw request lines
//            EnableMask  [N] lets Pending[i] reach Result/FirstIndex
//            ClearMask   [N] sticky bits to clear on ClearStrobe
//            ClearStrobe     one-cycle clear request, qualified by Tick
//            Pending     [N] registered pending bits (not masked)
//            Result          registered |(Pending & EnableMask)
//            FirstIndex  [IDX_W] lowest enabled pending index, 0 if none
// Revision : 1.0 - initial release
// ============================================================================
module pending_or_collector
    import pending_or_collector_pkg::*;
#(
    parameter int                      NR_OF_INPUTS = 15,
    parameter logic [c_MAX_INPUTS-1:0] BUBBLES_MASK = c_DEFAULT_BUBBLES_MASK,
    parameter logic [c_MAX_INPUTS-1:0] EDGE_MASK    = c_DEFAULT_EDGE_MASK,
    parameter int                      SYNC_STAGES  = 0,
    localparam int                     IDX_W        = idx_width(NR_OF_INPUTS)
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Tick,
    input  logic [NR_OF_INPUTS-1:0] Inputs,
    input  logic [NR_OF_INPUTS-1:0] EnableMask,
    input  logic [NR_OF_INPUTS-1:0] ClearMask,
    input  logic                    ClearStrobe,
    output logic [NR_OF_INPUTS-1:0] Pending,
    output logic                    Result,
    output logic [IDX_W-1:0]        FirstIndex
);

    logic [NR_OF_INPUTS-1:0] w_sync_out;
    logic [NR_OF_INPUTS-1:0] w_real;
    logic [NR_OF_INPUTS-1:0] w_pending_d;
    logic [NR_OF_INPUTS-1:0] w_active;
    logic                    w_any;
    logic [IDX_W-1:0]        w_idx;

    logic [NR_OF_INPUTS-1:0] r_pending_q;
    logic [NR_OF_INPUTS-1:0] r_prev_q;
    logic                    r_result_q;
    logic [IDX_W-1:0]        r_first_idx_q;

    for (genvar i = 0; i < NR_OF_INPUTS; i++) begin : g_bit

        if (SYNC_STAGES > 0) begin : g_sync
            // Shift chain per input; held with Tick=0 like all other state.
            logic [SYNC_STAGES-1:0] r_sync_q;

            always_ff @(posedge Clock) begin
                if (Reset) begin
                    r_sync_q <= '0;
                end else if (Tick) begin
                    r_sync_q[0] <= Inputs[i];
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        r_sync_q[s] <= r_sync_q[s-1];
                    end
                end
            end

            assign w_sync_out[i] = r_sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign w_sync_out[i] = Inputs[i];
        end

        assign w_real[i] = w_sync_out[i] ^ BUBBLES_MASK[i];

        // Edge bits: a new rising edge is ORed after the clear term, so a
        // set in the same cycle as a clear leaves the bit at 1.
        // Level bits simply follow the conditioned input.
        assign w_pending_d[i] = EDGE_MASK[i]
                              ? ((w_real[i] & ~r_prev_q[i])
                                 | (r_pending_q[i] & ~(ClearStrobe & ClearMask[i])))
                              : w_real[i];
    end

    // Masking only shapes Result/FirstIndex; Pending keeps masked bits.
    assign w_active = w_pending_d & EnableMask;

    lowest_set_index #(
        .WIDTH (NR_OF_INPUTS)
    ) u_lowest_set_index (
        .i_vec (w_active),
        .any   (w_any),
        .idx   (w_idx)
    );

    // prev resets to all ones so inputs already active at reset release do
    // not register as edges on the first enabled cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pending_q   <= '0;
            r_prev_q      <= '1;
            r_result_q    <= 1'b0;
            r_first_idx_q <= '0;
        end else if (Tick) begin
            r_pending_q   <= w_pending_d;
            r_prev_q      <= w_real;
            r_result_q    <= w_any;
            r_first_idx_q <= w_idx;
        end
    end

    assign Pending    = r_pending_q;
    assign Result     = r_result_q;
    assign FirstIndex = r_first_idx_q;

endmodule
`default_nettype wire
